ssram_arbiter: RTL
==================

// Module: ssram_arbiter
// PURPOSE
//  Shares one single-port ssram (1-cycle synchronous read, byte-enabled write) among NUM_REQ requesters.
//  Round-robin arbitration; per-port valid/ready request and response channels.
//  A 2-deep pipeline (issue, capture) allows one new sram access per cycle.
//  Each port has one registered response slot; read data is captured because ssram rdata is undefined when cs is low.
// PARAMETERS
//  NUM_WORDS  1024  sram depth (power of 2); AW = $clog2(NUM_WORDS)
//  DATA_LEN   64    word width; BW = (DATA_LEN+7)/8 byte enables
//  NUM_REQ    2     number of requesters, >=2; PW = $clog2(NUM_REQ)
// PORTS
//  clk_i          in   1             clock, rising edge
//  rst_n_i        in   1             asynchronous active-low reset
//  req_valid_i    in   NUM_REQ       request valid, per port
//  req_ready_o    out  NUM_REQ       request accepted this cycle (one-hot or zero)
//  req_we_i       in   NUM_REQ       1 = write, 0 = read
//  req_be_i       in   NUM_REQ*BW    byte enables, port p at [p*BW+:BW]; ignored on reads
//  req_addr_i     in   NUM_REQ*AW    word address, port p at [p*AW+:AW]
//  req_wdata_i    in   NUM_REQ*DATA_LEN  write data, port p at [p*DATA_LEN+:DATA_LEN]
//  resp_valid_o   out  NUM_REQ       response slot full
//  resp_ready_i   in   NUM_REQ       consumer pops response
//  resp_we_o      out  NUM_REQ       response is a write ack
//  resp_rdata_o   out  NUM_REQ*DATA_LEN  read data; '0 for write acks
//  sram_cs_o      out  1             sram chip select
//  sram_we_o      out  1             sram write enable
//  sram_be_o      out  BW            sram byte enables
//  sram_addr_o    out  AW            sram address
//  sram_wdata_o   out  DATA_LEN      sram write data
//  sram_rdata_i   in   DATA_LEN      sram read data, valid the cycle after a read issue
// BEHAVIOUR
//  Reset: all resp_valid_o=0, resp_we_o=0, resp_rdata_o=0, inflight cleared, rr pointer=0; sram_cs_o=0, req_ready_o=0.
//  Eligible(p) = req_valid_i[p] && !(infl_q && infl_port_q==p) && (!resp_valid_o[p] || resp_ready_i[p]).
//  Grant: first eligible port starting at rr pointer, wrapping modulo NUM_REQ. At most one grant per cycle.
//  Issue cycle (combinational): req_ready_o[g]=1; sram_cs_o=1; sram_we/be/addr/wdata driven from port g.
//   On reads sram_be_o = all ones. With no grant: sram_cs_o=0, sram_we_o=0, other sram outputs '0.
//  On a grant edge: infl_q<=1, infl_port_q<=g, infl_we_q<=we; rr pointer <= (g+1) mod NUM_REQ. Otherwise infl_q<=0.
//   The pointer holds when there is no grant.
//  Capture (cycle after issue, infl_q=1): at the edge, resp slot[infl_port_q] <= {valid=1, we=infl_we_q,
//   rdata = infl_we_q ? '0 : sram_rdata_i}.
//  Latency: request accepted at edge N; response visible after edge N+1 (2 cycles, req fire to resp_valid).
//  Throughput: 1 access/cycle across ports. A single port issues at most every 2nd cycle (inflight block).
//   A single port can reach 1 per 2 cycles while it pops its responses immediately.
//  Slot pop: resp_valid_o[p] && resp_ready_i[p] clears the slot at the edge, unless a capture for p
//   happens at the same edge. In that case capture wins (slot stays valid with the new data).
//  Simultaneous pop + new grant for same port is legal: slot frees at edge N, data lands at edge N+1.
//  Slot never overwritten while valid and not popped; this is guaranteed by Eligible().
//  Requests must hold stable while valid && !ready; the arbiter never drops an accepted request.
//  Write then read of the same address on consecutive issues returns the new data (sram write completes at issue edge).
//  Async reset mid-operation: inflight access and all responses discarded; the sram write already sampled stays in memory.
// TESTING
//  1 Single read: p0 read addr 5 (pre-written 0xDEAD_BEEF) -> ready same cycle, resp_valid_o[0] 2 cycles later,
//    rdata 0xDEAD_BEEF, resp_we_o=0.
//  2 Byte write: p1 write addr 3, be=8'h0F, wdata=64'h1111_2222_3333_4444 over 0 -> write ack (rdata 0);
//    read back gives 64'h0000_0000_3333_4444.
//  3 Contention: p0,p1 both valid continuously with resp_ready=1 -> grants alternate p0,p1,p0,...;
//    sram_cs_o=1 every cycle after the first.
//  4 Backpressure: p0 resp_ready=0 with a full slot -> req_ready_o[0] stays 0 while p1 is served;
//    raising resp_ready re-enables p0 the same cycle.
//  5 Same-port burst, single requester: p0 issues 4 reads -> ready on alternate cycles;
//    responses arrive in order with correct data.
//  6 Reset mid-op: assert rst_n_i=0 the cycle after issue -> no resp_valid after release; rr pointer=0;
//    sram_cs_o=0 while reset is asserted.

Source files
------------

// File: rtl/ssram_arbiter.sv
// Round-robin arbiter sharing one single-port synchronous SRAM among NUM_REQ requesters.
// Two-stage pipeline: combinational issue, then capture into a per-port response slot.
module ssram_arbiter #(
  parameter  int unsigned NUM_WORDS = 1024,
  parameter  int unsigned DATA_LEN  = 64,
  parameter  int unsigned NUM_REQ   = 2,
  localparam int unsigned AW        = $clog2(NUM_WORDS),
  localparam int unsigned BW        = (DATA_LEN + 7) / 8,
  localparam int unsigned PW        = $clog2(NUM_REQ)
) (
  input  logic                         clk_i,
  input  logic                         rst_n_i,
  input  logic [NUM_REQ-1:0]           req_valid_i,
  output logic [NUM_REQ-1:0]           req_ready_o,
  input  logic [NUM_REQ-1:0]           req_we_i,
  input  logic [NUM_REQ*BW-1:0]        req_be_i,
  input  logic [NUM_REQ*AW-1:0]        req_addr_i,
  input  logic [NUM_REQ*DATA_LEN-1:0]  req_wdata_i,
  output logic [NUM_REQ-1:0]           resp_valid_o,
  input  logic [NUM_REQ-1:0]           resp_ready_i,
  output logic [NUM_REQ-1:0]           resp_we_o,
  output logic [NUM_REQ*DATA_LEN-1:0]  resp_rdata_o,
  output logic                         sram_cs_o,
  output logic                         sram_we_o,
  output logic [BW-1:0]                sram_be_o,
  output logic [AW-1:0]                sram_addr_o,
  output logic [DATA_LEN-1:0]          sram_wdata_o,
  input  logic [DATA_LEN-1:0]          sram_rdata_i
);

  logic [BW-1:0]       be_a    [NUM_REQ];
  logic [AW-1:0]       addr_a  [NUM_REQ];
  logic [DATA_LEN-1:0] wdata_a [NUM_REQ];

  logic                infl_q;
  logic [PW-1:0]       infl_port_q;
  logic                infl_we_q;
  logic [PW-1:0]       rr_q;

  logic [NUM_REQ-1:0]                resp_valid_q;
  logic [NUM_REQ-1:0]                resp_we_q;
  logic [NUM_REQ-1:0][DATA_LEN-1:0]  resp_rdata_q;

  logic [NUM_REQ-1:0]  eligible_c;
  logic                gnt_valid_c;
  logic [PW-1:0]       gnt_idx_c;
  logic [PW-1:0]       cand_c;
  logic [PW-1:0]       rr_next_c;

  for (genvar p = 0; p < NUM_REQ; p++) begin : g_unpack
    assign be_a[p]    = req_be_i[p*BW +: BW];
    assign addr_a[p]  = req_addr_i[p*AW +: AW];
    assign wdata_a[p] = req_wdata_i[p*DATA_LEN +: DATA_LEN];
  end

  // A port may issue only if it is not in flight and its slot is free or being popped.
  always_comb begin
    eligible_c = '0;
    for (int unsigned p = 0; p < NUM_REQ; p++) begin
      eligible_c[p] = rst_n_i && req_valid_i[p]
                   && !(infl_q && (infl_port_q == PW'(p)))
                   && (!resp_valid_q[p] || resp_ready_i[p]);
    end
  end

  // First eligible port at or after the round-robin pointer.
  always_comb begin
    gnt_valid_c = 1'b0;
    gnt_idx_c   = '0;
    cand_c      = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      cand_c = PW'((32'(rr_q) + i) % NUM_REQ);
      if (!gnt_valid_c && eligible_c[cand_c]) begin
        gnt_valid_c = 1'b1;
        gnt_idx_c   = cand_c;
      end
    end
  end

  assign rr_next_c = (gnt_idx_c == PW'(NUM_REQ - 1)) ? '0 : gnt_idx_c + 1'b1;

  always_comb begin
    req_ready_o  = '0;
    sram_cs_o    = 1'b0;
    sram_we_o    = 1'b0;
    sram_be_o    = '0;
    sram_addr_o  = '0;
    sram_wdata_o = '0;
    if (gnt_valid_c) begin
      req_ready_o[gnt_idx_c] = 1'b1;
      sram_cs_o    = 1'b1;
      sram_we_o    = req_we_i[gnt_idx_c];
      sram_be_o    = req_we_i[gnt_idx_c] ? be_a[gnt_idx_c] : '1;
      sram_addr_o  = addr_a[gnt_idx_c];
      sram_wdata_o = wdata_a[gnt_idx_c];
    end
  end

  // Capture has priority over a pop on the same slot at the same edge.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      infl_q       <= 1'b0;
      infl_port_q  <= '0;
      infl_we_q    <= 1'b0;
      rr_q         <= '0;
      resp_valid_q <= '0;
      resp_we_q    <= '0;
      resp_rdata_q <= '0;
    end else begin
      infl_q <= gnt_valid_c;
      if (gnt_valid_c) begin
        infl_port_q <= gnt_idx_c;
        infl_we_q   <= req_we_i[gnt_idx_c];
        rr_q        <= rr_next_c;
      end
      for (int unsigned p = 0; p < NUM_REQ; p++) begin
        if (infl_q && (infl_port_q == PW'(p))) begin
          resp_valid_q[p] <= 1'b1;
          resp_we_q[p]    <= infl_we_q;
          resp_rdata_q[p] <= infl_we_q ? '0 : sram_rdata_i;
        end else if (resp_valid_q[p] && resp_ready_i[p]) begin
          resp_valid_q[p] <= 1'b0;
        end
      end
    end
  end

  assign resp_valid_o = resp_valid_q;
  assign resp_we_o    = resp_we_q;
  assign resp_rdata_o = resp_rdata_q;

endmodule
